// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, register map, STATUS layout and
// the oversampling factor.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  localparam int unsigned Oversample = 16;

  localparam logic [31:0] RegData   = 32'h0000_0000;
  localparam logic [31:0] RegStatus = 32'h0000_0004;

  localparam int unsigned StatNotEmpty = 0;
  localparam int unsigned StatOverrun  = 1;
  localparam int unsigned StatFraming  = 2;
  localparam int unsigned StatParity   = 3;
  localparam int unsigned StatCountLsb = 4;
  localparam int unsigned StatCountMsb = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; pointers carry one extra bit so full and empty
// are distinguishable when the address bits match.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr_q[AddrW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: 16x oversampled frame decoder, receive FIFO and a DATA/STATUS
// register pair. Define UART_RX_PARITY_EN for 8E1 frames; the default build decodes 8N1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQUENCY  = 50000000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  input  logic        UART_RX
);

  localparam int unsigned Div  = FREQUENCY / (BAUDRATE * Oversample);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic unused_bus;
  assign unused_bus = ^{i_wdata, i_address[31:3], i_address[1:0]};

  // Tick generator: free-running, never realigned to frames.
  logic [31:0] div_cnt_q;
  logic        tick;

  assign tick = (div_cnt_q == 32'(Div - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) div_cnt_q <= '0;
    else         div_cnt_q <= tick ? '0 : div_cnt_q + 32'd1;
  end

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic fall;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;

  // Receive FSM
  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       mid;
  logic       push, set_fe, set_pe, frame_bad;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign frame_bad = par_err_q;
`else
  assign frame_bad = 1'b0;
`endif

  assign mid = tick && (cnt_q == 4'd7);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_fe    = 1'b0;
    set_pe    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    // The sample counter wraps every 16 ticks, so count 7 recurs once per bit.
    if (state_q != StIdle && tick) cnt_d = cnt_q + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (mid) begin
          if (rx_sync_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end
      end
      StData: begin
        if (mid) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (mid) begin
          par_err_d = ^{shift_q, rx_sync_q};
          set_pe    = ^{shift_q, rx_sync_q};
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (mid) begin
          state_d = StIdle;
          if (!rx_sync_q)     set_fe = 1'b1;
          else if (!frame_bad) push  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [7:0]      head;
  logic            full, empty, pop;
  logic [CntW-1:0] count;

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock (i_clock),
    .reset (i_reset),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Bus side: one pop / sticky clear per request, gated by the serviced flag.
  logic serviced_q, req, is_status, clr;
  logic overrun_q, framing_q, parity_flag;
  logic [31:0] status_word;

  assign req       = i_enable & ~serviced_q;
  assign is_status = (i_address[2] == RegStatus[2]);
  assign pop       = req & ~i_rw & ~is_status & ~empty;
  assign clr       = req & ~i_rw & is_status;

`ifdef UART_RX_PARITY_EN
  logic parity_q;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) parity_q <= 1'b0;
    else         parity_q <= set_pe | (parity_q & ~clr);
  end
  assign parity_flag = parity_q;
`else
  logic unused_pe;
  assign unused_pe   = set_pe;
  assign parity_flag = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      overrun_q <= (push & full) | (overrun_q & ~clr);
      framing_q <= set_fe | (framing_q & ~clr);
    end
  end

  always_comb begin
    status_word                            = '0;
    status_word[StatNotEmpty]              = ~empty;
    status_word[StatOverrun]               = overrun_q;
    status_word[StatFraming]               = framing_q;
    status_word[StatParity]                = parity_flag;
    status_word[StatCountMsb:StatCountLsb] = 5'(count);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_ready    <= 1'b0;
      o_rdata    <= '0;
      serviced_q <= 1'b0;
    end else if (req) begin
      o_ready    <= 1'b1;
      serviced_q <= 1'b1;
      if (i_rw)           o_rdata <= '0;
      else if (is_status) o_rdata <= status_word;
      else if (empty)     o_rdata <= '0;
      else                o_rdata <= {24'b0, head};
    end else if (!i_enable) begin
      o_ready    <= 1'b0;
      serviced_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames go through a byte-level reference model, reads push
// their expected word, and a monitor checks each bus completion.
module tb_uart_rx;

  localparam int unsigned Freq  = 6144000;
  localparam int unsigned Baud  = 96000;
  localparam int unsigned Depth = 16;
  localparam int unsigned Bit   = Freq / Baud;  // 64 clocks per bit

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        rx = 1'b1;

  always #5 clk = ~clk;

  uart_rx #(
    .FREQUENCY (Freq),
    .BAUDRATE  (Baud),
    .FIFO_DEPTH(Depth)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_enable (en),
    .i_rw     (rw),
    .i_address(addr),
    .i_wdata  (wdata),
    .o_rdata  (rdata),
    .o_ready  (ready),
    .UART_RX  (rx)
  );

  typedef struct {
    string       name;
    bit          chk;
    logic [31:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  bit         m_ovr, m_fe, m_pe;
  int         total = 0;
  int         bad = 0;
  bit         prev_ready = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] status_model();
    logic [31:0] s;
    s      = '0;
    s[0]   = (model_q.size() != 0);
    s[1]   = m_ovr;
    s[2]   = m_fe;
    s[3]   = m_pe;
    s[8:4] = 5'(model_q.size());
    return s;
  endfunction

  // Frame outcome from its bit contents: parity check, then stop bit, then FIFO capacity.
  function automatic void apply_model(logic [7:0] d, bit par, bit stop);
    bit perr;
    perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = ^{d, par};
    if (perr) m_pe = 1'b1;
`else
    if (par) perr = 1'b0;
`endif
    if (!stop) m_fe = 1'b1;
    else if (!perr) begin
      if (model_q.size() < Depth) model_q.push_back(d);
      else m_ovr = 1'b1;
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (ready && !prev_ready) begin
        if (exp_q.size() == 0) check("unexpected_ready", {31'b0, ready}, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.chk) check(e.name, rdata, e.val);
        end
      end
      prev_ready = ready;
    end
  end

  task automatic bus(input bit w, input logic [31:0] a, input string name, input bit chk,
                     input logic [31:0] expv);
    int n;
    exp_q.push_back('{name, chk, expv});
    @(negedge clk);
    en = 1'b1; rw = w; addr = a;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({name, "_timeout"}, {31'b0, ready}, 32'd1);
    en = 1'b0;
    n = 0;
    while (ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic read_data(input string name);
    logic [31:0] e;
    e = '0;
    if (model_q.size() > 0) e = {24'b0, model_q.pop_front()};
    bus(1'b0, 32'h0, name, 1'b1, e);
  endtask

  task automatic read_status(input string name);
    logic [31:0] e;
    e = status_model();
    m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    bus(1'b0, 32'h4, name, 1'b1, e);
  endtask

  task automatic drive(input bit v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] d, input bit par, input bit stop);
    drive(1'b0, Bit);
    for (int i = 0; i < 8; i++) drive(d[i], Bit);
`ifdef UART_RX_PARITY_EN
    drive(par, Bit);
`endif
    drive(stop, Bit);
    rx = 1'b1;
    apply_model(d, par, stop);
  endtask

  task automatic send(input logic [7:0] d);
    send_raw(d, ^d, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame
    send(8'hA5);
    read_status("a5_status");
    read_data("a5_data");
    read_status("a5_status_after");

    // Back-to-back frames
    send(8'h00); send(8'hFF); send(8'h3C);
    repeat (3) read_data("b2b_data");
    read_status("b2b_status");

    // Overrun
    for (int i = 0; i < 17; i++) send(8'($urandom));
    read_status("ovr_status");
    read_status("ovr_cleared");
    for (int i = 0; i < 16; i++) read_data("ovr_data");
    read_data("empty_data");

    // Short glitch rejected; a low pulse past mid-start decodes as a frame of ones
    drive(1'b0, Bit / 8);
    drive(1'b1, 3 * Bit);
    read_status("glitch_status");
    drive(1'b0, (Bit * 11) / 16);
    drive(1'b1, 11 * Bit);
    apply_model(8'hFF, 1'b1, 1'b1);
    read_status("pulse_status");
    read_data("pulse_data");

    // Framing error, then a held-low break reporting once
    send_raw(8'h55, ^8'h55, 1'b0);
    read_status("frame_err_status");
    rx = 1'b0;
    repeat (12 * Bit) @(negedge clk);
    apply_model(8'h00, 1'b0, 1'b0);
    read_status("break_status");
    repeat (8 * Bit) @(negedge clk);
    rx = 1'b1;
    repeat (2 * Bit) @(negedge clk);
    read_status("break_single");

`ifdef UART_RX_PARITY_EN
    send_raw(8'h07, 1'b1, 1'b1);
    read_data("par_good_data");
    send_raw(8'h07, 1'b0, 1'b1);
    read_status("par_bad_status");
`endif

    // Random frames with occasional bad stop/parity bits
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      bit         stop, par;
      d    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      par  = (^d) ^ ($urandom_range(3) == 0);
      send_raw(d, par, stop);
      if ($urandom_range(1) == 1) read_status("rand_status");
    end
    while (model_q.size() > 0) read_data("rand_data");
    read_status("rand_final_status");

    // Writes have no side effects
    send(8'h81);
    bus(1'b1, 32'h0, "write", 1'b0, 32'h0);
    read_status("write_status");
    read_data("write_data");

    // Reset mid-frame
    send(8'h11);
    drive(1'b0, Bit);
    drive(1'b0, Bit); drive(1'b1, Bit); drive(1'b0, Bit);
    rst = 1'b1;
    rx = 1'b1;
    model_q.delete();
    m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_ready", {31'b0, ready}, 32'd0);
    check("midreset_rdata", rdata, 32'd0);
    rst = 1'b0;
    repeat (2 * Bit) @(negedge clk);
    read_status("midreset_status");
    send(8'h5A);
    read_data("post_reset_data");
    read_status("post_reset_status");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
